wb_regfile_stage: RTL and testbench

//  Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural

---
 rtl/mips_pkg.sv | 28 ++
 rtl/wb_regfile_stage_regfile.sv | 48 ++++
 rtl/wb_regfile_stage.sv | 108 ++++++++++
 tb/tb_wb_regfile_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline back end: datapath width, MemtoReg
// encodings and architectural register indices.
// Pure declarations, no latency; no flow control involved.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;

    // Write-back data source selected by the MEM/WB MemtoReg field.
    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,   // ALU result
        MTR_MEM  = 2'b01,   // load data
        MTR_LINK = 2'b10,   // return address for jal/jalr
        MTR_EPC  = 2'b11    // exception return address (pc itself)
    } mtr_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    // A write only has architectural effect when enabled and not aimed at $0.
    function automatic logic is_live_write(input logic we, input reg_idx_t addr);
        return we && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_stage_regfile.sv
// 32-entry register array with two combinational read ports, a debug read tap and one write port.
// Reads zero latency; write visible in the array after the clock edge; $0 always reads zero.
// No backpressure: a write is accepted every cycle it is enabled.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   we, waddr, wdata      write port (ignored when waddr == $0 or during reset)
//   ra_addr / ra_data     read port A (no write-through here; bypass lives in the stage)
//   rb_addr / rb_data     read port B
//   rc_addr / rc_data     debug read tap, raw array contents
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int               W       = DATA_W,
    parameter logic [W-1:0]     SP_INIT = W'(32'h0000_0800)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  reg_idx_t        waddr,
    input  logic [W-1:0]    wdata,
    input  reg_idx_t        ra_addr,
    output logic [W-1:0]    ra_data,
    input  reg_idx_t        rb_addr,
    output logic [W-1:0]    rb_data,
    input  reg_idx_t        rc_addr,
    output logic [W-1:0]    rc_data
);

    logic [W-1:0] regs [NUM_REGS];

    // Entry 0 is reset to zero and never written, so it stays a constant and
    // gets optimised away; the read muxes still force zero for clarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (reg_idx_t'(i) == REG_SP) ? SP_INIT : '0;
            end
        end else if (is_live_write(we, waddr)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == REG_ZERO) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == REG_ZERO) ? '0 : regs[rb_addr];
    assign rc_data = (rc_addr == REG_ZERO) ? '0 : regs[rc_addr];

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage plus architectural register file: selects WB data, commits it, serves ID reads.
// Reads and forwarding outputs are combinational; commit and dbg_data take effect at the next edge.
// No backpressure: the MEM/WB register holds or inserts bubbles (RegWr_in=0) upstream.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   MemtoReg_in, RegWr_in, pc_in,
//   RdData_in, ALUOut_in, WrAddr_in  retiring instruction from the MEM/WB register
//   rs_addr/rs_data, rt_addr/rt_data ID-stage read ports with same-cycle write-through
//   fwd_valid, fwd_addr, fwd_data    in-flight WB write exported to the forwarding unit
//   dbg_addr/dbg_data                registered debug read of the array (1-cycle latency)
//   wr_count                         committed register writes since reset (wraps)
module wb_regfile_stage
    import mips_pkg::*;
#(
    parameter int                   DATA_W   = mips_pkg::DATA_W,
    parameter logic [DATA_W-1:0]    SP_INIT  = DATA_W'(32'h0000_0800),
    parameter logic [DATA_W-1:0]    LINK_OFS = DATA_W'(32'd4),
    parameter int                   CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          MemtoReg_in,
    input  logic                RegWr_in,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   RdData_in,
    input  logic [DATA_W-1:0]   ALUOut_in,
    input  logic [4:0]          WrAddr_in,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    output logic [DATA_W-1:0]   rs_data,
    output logic [DATA_W-1:0]   rt_data,
    output logic                fwd_valid,
    output logic [4:0]          fwd_addr,
    output logic [DATA_W-1:0]   fwd_data,
    input  logic [4:0]          dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [CNT_W-1:0]    wr_count
);

    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] arr_rs;
    logic [DATA_W-1:0] arr_rt;
    logic [DATA_W-1:0] arr_dbg;
    logic              wr_live;

    // Write-back data select. Link address wraps naturally at DATA_W bits.
    always_comb begin
        wb_data = ALUOut_in;
        case (mtr_e'(MemtoReg_in))
            MTR_ALU:  wb_data = ALUOut_in;
            MTR_MEM:  wb_data = RdData_in;
            MTR_LINK: wb_data = pc_in + LINK_OFS;
            MTR_EPC:  wb_data = pc_in;
            default:  wb_data = ALUOut_in;
        endcase
    end

    assign wr_live = is_live_write(RegWr_in, WrAddr_in);

    regfile_2r1w #(
        .W       (DATA_W),
        .SP_INIT (SP_INIT)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (RegWr_in),
        .waddr   (WrAddr_in),
        .wdata   (wb_data),
        .ra_addr (rs_addr),
        .ra_data (arr_rs),
        .rb_addr (rt_addr),
        .rb_data (arr_rt),
        .rc_addr (dbg_addr),
        .rc_data (arr_dbg)
    );

    // Write-through: an ID read of the register being written this cycle sees
    // the new value. This deliberately ignores reset, so the combinational
    // view keeps following the inputs even while the commit is being dropped.
    // wr_live already excludes $0, so a $0 read can never pick up wb_data.
    assign rs_data = (wr_live && (rs_addr == WrAddr_in)) ? wb_data : arr_rs;
    assign rt_data = (wr_live && (rt_addr == WrAddr_in)) ? wb_data : arr_rt;

    assign fwd_valid = wr_live;
    assign fwd_addr  = WrAddr_in;
    assign fwd_data  = wb_data;

    // Debug tap samples the array before this edge's write lands (no bypass),
    // which is what a debugger polling committed state expects.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= arr_dbg;
        end
    end

    // Counts exactly the writes that reach the array; rolls over silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (wr_live) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed scenarios plus randomized
// traffic checked against a behavioural register-file model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  MemtoReg_in;
    logic        RegWr_in;
    logic [31:0] pc_in;
    logic [31:0] RdData_in;
    logic [31:0] ALUOut_in;
    logic [4:0]  WrAddr_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [3:0]  wr_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: architectural register contents and commit count.
    logic [31:0] mregs [32];
    int          mcount;
    logic [31:0] exp_dbg;

    wb_regfile_stage #(
        .DATA_W   (32),
        .SP_INIT  (32'h0000_0800),
        .LINK_OFS (32'd4),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemtoReg_in (MemtoReg_in),
        .RegWr_in    (RegWr_in),
        .pc_in       (pc_in),
        .RdData_in   (RdData_in),
        .ALUOut_in   (ALUOut_in),
        .WrAddr_in   (WrAddr_in),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_wb();
        case (MemtoReg_in)
            2'd0:    return ALUOut_in;
            2'd1:    return RdData_in;
            2'd2:    return pc_in + 32'd4;
            default: return pc_in;
        endcase
    endfunction

    function automatic logic m_fwd_valid();
        return RegWr_in && (WrAddr_in != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (m_fwd_valid() && idx == WrAddr_in) return m_wb();
        return mregs[idx];
    endfunction

    task automatic m_init();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mregs[29] = 32'h0000_0800;
        mcount = 0;
    endtask

    // Advance one clock, updating the model with what the edge should commit.
    task automatic tick();
        logic [31:0] wb;
        wb = m_wb();
        exp_dbg = reset ? 32'd0 : mregs[dbg_addr];
        if (reset) begin
            m_init();
        end else if (m_fwd_valid()) begin
            mregs[WrAddr_in] = wb;
            mcount = (mcount + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; MemtoReg_in = 2'd0; RegWr_in = 1'b0;
        pc_in = 32'd0; RdData_in = 32'd0; ALUOut_in = 32'd0;
        WrAddr_in = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] e;
        idle_inputs();
        reset = 1'b1; RegWr_in = 1'b1; WrAddr_in = 5'd3; ALUOut_in = 32'h0000_ABCD;
        tick();
        reset = 1'b0; RegWr_in = 1'b0;
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL reset_wr_count got=%h exp=0", wr_count); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            e = (i == 29) ? 32'h800 : 32'd0;
            checks++; if (rs_data !== e) begin errors++; $display("FAIL reset_rs[%0d] got=%h exp=%h", i, rs_data, e); end
            e = (31 - i == 29) ? 32'h800 : 32'd0;
            checks++; if (rt_data !== e) begin errors++; $display("FAIL reset_rt[%0d] got=%h exp=%h", 31 - i, rt_data, e); end
            tick();
            e = (i == 29) ? 32'h800 : 32'd0;
            checks++; if (dbg_data !== e) begin errors++; $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, dbg_data, e); end
        end
    endtask

    task automatic test_alu_write();
        idle_inputs();
        MemtoReg_in = 2'd0; RegWr_in = 1'b1; WrAddr_in = 5'd8; ALUOut_in = 32'hDEAD_BEEF;
        rs_addr = 5'd8; rt_addr = 5'd9; dbg_addr = 5'd8;
        #1;
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_bypass_rs got=%h exp=deadbeef", rs_data); end
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL alu_rt_nohit got=%h exp=0", rt_data); end
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid got=%b exp=1", fwd_valid); end
        checks++; if (fwd_addr !== 5'd8) begin errors++; $display("FAIL alu_fwd_addr got=%0d exp=8", fwd_addr); end
        checks++; if (fwd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_fwd_data got=%h exp=deadbeef", fwd_data); end
        tick();
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL alu_dbg_prewrite got=%h exp=0", dbg_data); end
        checks++; if (wr_count !== 4'd1) begin errors++; $display("FAIL alu_wr_count got=%h exp=1", wr_count); end
        RegWr_in = 1'b0; ALUOut_in = 32'd0;
        #1;
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_array_rs got=%h exp=deadbeef", rs_data); end
        tick();
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_dbg_post got=%h exp=deadbeef", dbg_data); end
    endtask

    task automatic test_load_link();
        idle_inputs();
        RegWr_in = 1'b1; MemtoReg_in = 2'd1; RdData_in = 32'h1234; ALUOut_in = 32'hFFFF; WrAddr_in = 5'd9;
        #1;
        checks++; if (fwd_data !== 32'h1234) begin errors++; $display("FAIL load_fwd got=%h exp=1234", fwd_data); end
        tick();
        MemtoReg_in = 2'd2; pc_in = 32'h8000_0010; WrAddr_in = 5'd31;
        #1;
        checks++; if (fwd_data !== 32'h8000_0014) begin errors++; $display("FAIL link_fwd got=%h exp=80000014", fwd_data); end
        tick();
        MemtoReg_in = 2'd3; WrAddr_in = 5'd26;
        #1;
        checks++; if (fwd_data !== 32'h8000_0010) begin errors++; $display("FAIL epc_fwd got=%h exp=80000010", fwd_data); end
        tick();
        MemtoReg_in = 2'd2; pc_in = 32'hFFFF_FFFE; WrAddr_in = 5'd7;
        #1;
        checks++; if (fwd_data !== 32'h0000_0002) begin errors++; $display("FAIL link_wrap got=%h exp=2", fwd_data); end
        tick();
        RegWr_in = 1'b0; rs_addr = 5'd31; rt_addr = 5'd26;
        #1;
        checks++; if (rs_data !== 32'h8000_0014) begin errors++; $display("FAIL ra_read got=%h exp=80000014", rs_data); end
        checks++; if (rt_data !== 32'h8000_0010) begin errors++; $display("FAIL r26_read got=%h exp=80000010", rt_data); end
        rs_addr = 5'd9; rt_addr = 5'd7;
        #1;
        checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL r9_read got=%h exp=1234", rs_data); end
        checks++; if (rt_data !== 32'h2) begin errors++; $display("FAIL r7_read got=%h exp=2", rt_data); end
        checks++; if (wr_count !== 4'd5) begin errors++; $display("FAIL load_link_count got=%h exp=5", wr_count); end
    endtask

    task automatic test_zero_guard();
        int cnt_before;
        idle_inputs();
        RegWr_in = 1'b1; WrAddr_in = 5'd0; ALUOut_in = 32'hFFFF_FFFF;
        rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_rs got=%h exp=0", rs_data); end
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL zero_rt got=%h exp=0", rt_data); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL zero_fwd_valid got=%b exp=0", fwd_valid); end
        checks++; if (fwd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_fwd_data got=%h exp=ffffffff", fwd_data); end
        cnt_before = mcount;
        tick();
        checks++; if (wr_count !== 4'(cnt_before)) begin errors++; $display("FAIL zero_count got=%h exp=%h", wr_count, 4'(cnt_before)); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL zero_dbg got=%h exp=0", dbg_data); end
        RegWr_in = 1'b0;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_after got=%h exp=0", rs_data); end
    endtask

    task automatic test_reset_write();
        idle_inputs();
        RegWr_in = 1'b1; WrAddr_in = 5'd5; ALUOut_in = 32'h55;
        tick();
        reset = 1'b1; ALUOut_in = 32'h66; rs_addr = 5'd5;
        #1;
        checks++; if (rs_data !== 32'h66) begin errors++; $display("FAIL rst_writethrough got=%h exp=66", rs_data); end
        tick();
        reset = 1'b0; RegWr_in = 1'b0; ALUOut_in = 32'h77;
        #1;
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL rst_dropped got=%h exp=0", rs_data); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL bubble_fwd_valid got=%b exp=0", fwd_valid); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%h exp=0", wr_count); end
        tick();
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL bubble_noop got=%h exp=0", rs_data); end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL bubble_count got=%h exp=0", wr_count); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v = 32'd0;
        for (int k = 0; k < 16; k++) begin
            v = $urandom;
            RegWr_in = 1'b1; WrAddr_in = 5'd12; ALUOut_in = v; rs_addr = 5'd12; rt_addr = 5'd12;
            #1;
            checks++; if (rs_data !== v) begin errors++; $display("FAIL wrap_rs[%0d] got=%h exp=%h", k, rs_data, v); end
            checks++; if (rt_data !== v) begin errors++; $display("FAIL wrap_rt[%0d] got=%h exp=%h", k, rt_data, v); end
            tick();
            checks++; if (wr_count !== 4'(k + 1)) begin errors++; $display("FAIL wrap_count[%0d] got=%h exp=%h", k, wr_count, 4'(k + 1)); end
        end
        checks++; if (wr_count !== 4'd0) begin errors++; $display("FAIL wrap_final got=%h exp=0", wr_count); end
        RegWr_in = 1'b0;
        #1;
        checks++; if (rs_data !== v) begin errors++; $display("FAIL wrap_last_wins got=%h exp=%h", rs_data, v); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 39) == 0);
            RegWr_in    = $urandom_range(0, 1) != 0;
            MemtoReg_in = 2'($urandom_range(0, 3));
            WrAddr_in   = 5'($urandom_range(0, 31));
            pc_in       = $urandom;
            RdData_in   = $urandom;
            ALUOut_in   = $urandom;
            rs_addr     = ($urandom_range(0, 3) == 0) ? WrAddr_in : 5'($urandom_range(0, 31));
            rt_addr     = ($urandom_range(0, 3) == 0) ? WrAddr_in : 5'($urandom_range(0, 31));
            dbg_addr    = 5'($urandom_range(0, 31));
            #1;
            e = m_read(rs_addr);
            checks++; if (rs_data !== e) begin errors++; $display("FAIL rnd_rs[%0d] got=%h exp=%h", n, rs_data, e); end
            e = m_read(rt_addr);
            checks++; if (rt_data !== e) begin errors++; $display("FAIL rnd_rt[%0d] got=%h exp=%h", n, rt_data, e); end
            checks++; if (fwd_valid !== m_fwd_valid()) begin errors++; $display("FAIL rnd_fwd_valid[%0d] got=%b exp=%b", n, fwd_valid, m_fwd_valid()); end
            checks++; if (fwd_addr !== WrAddr_in) begin errors++; $display("FAIL rnd_fwd_addr[%0d] got=%0d exp=%0d", n, fwd_addr, WrAddr_in); end
            e = m_wb();
            checks++; if (fwd_data !== e) begin errors++; $display("FAIL rnd_fwd_data[%0d] got=%h exp=%h", n, fwd_data, e); end
            tick();
            checks++; if (dbg_data !== exp_dbg) begin errors++; $display("FAIL rnd_dbg[%0d] got=%h exp=%h", n, dbg_data, exp_dbg); end
            checks++; if (wr_count !== 4'(mcount)) begin errors++; $display("FAIL rnd_count[%0d] got=%h exp=%h", n, wr_count, 4'(mcount)); end
        end
        idle_inputs();
    endtask

    initial begin
        m_init();
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_link();
        test_zero_guard();
        test_reset_write();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
